// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction-fetch controller that owns the program counter. One FSM decides
// when a fetch is issued to instruction memory, when a returned word is
// presented to decode, and what value the PC takes next (sequential advance,
// branch/jump redirect, trap entry). At most one memory request is ever
// outstanding. A halt request parks the fetch unit between instructions.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   imem_req       one-cycle fetch request (high while in REQ)
//   imem_addr      fetch address, always the current PC
//   imem_rvalid    memory read data valid (honoured only in WAIT)
//   imem_rdata     instruction word returned by memory
//   instr_valid    instruction held for decode (high while in HOLD)
//   instr          held instruction word
//   instr_pc       PC the held instruction was fetched from
//   instr_ready    decode accepts the held instruction
//   redirect_valid branch/jump taken, one-cycle pulse
//   redirect_pc    redirect target
//   trap_valid     trap entry, one-cycle pulse (wins over redirect)
//   halt_req       level; fetch parks in HALT while high
//   misalign_err   one-cycle pulse after a redirect to a non-word-aligned target
module fetch_sequencer #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [N-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  input  logic         trap_valid,
  input  logic         halt_req,
  output logic         misalign_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  localparam logic [N-1:0] PC_STEP = N'(4);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] pc;
  logic [N-1:0] pc_next;
  logic         kill;
  logic         kill_next;
  logic         capture;

  logic         ctrl;
  logic         redirect_misaligned;
  logic         misalign_next;
  logic [N-1:0] ctrl_pc;
  state_t       resume_state;

  // Control-flow decode. A trap always wins; a redirect to a target whose low
  // two bits are non-zero is turned into a trap-vector jump and flagged so the
  // core can record the exception. The flag is registered, so it pulses in the
  // cycle after the offending redirect.
  always_comb begin
    ctrl                = trap_valid | redirect_valid;
    redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    misalign_next       = redirect_valid & ~trap_valid & redirect_misaligned;
    ctrl_pc             = (trap_valid | redirect_misaligned) ? TRAP_VEC : redirect_pc;
    // halt_req only matters at the points where a new request would begin.
    resume_state        = halt_req ? HALT : REQ;
  end

  // Next-state and next-PC logic. kill marks an outstanding request whose
  // response must be thrown away because the PC moved after it was issued.
  // A redirect arriving in the same WAIT cycle as the response discards that
  // response directly, so kill is not needed for that case.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    capture    = 1'b0;

    case (state)
      IDLE: begin
        if (ctrl) begin
          pc_next = ctrl_pc;
        end
        state_next = resume_state;
      end

      REQ: begin
        state_next = WAIT;
        if (ctrl) begin
          pc_next   = ctrl_pc;
          kill_next = 1'b1;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (kill || ctrl) begin
            kill_next  = 1'b0;
            state_next = resume_state;
            if (ctrl) begin
              pc_next = ctrl_pc;
            end
          end else begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end else if (ctrl) begin
          pc_next   = ctrl_pc;
          kill_next = 1'b1;
        end
      end

      HOLD: begin
        // A redirect squashes the held instruction even if decode takes it
        // in the same cycle.
        if (ctrl) begin
          pc_next    = ctrl_pc;
          state_next = REQ;
        end else if (instr_ready) begin
          pc_next    = pc + PC_STEP;
          state_next = resume_state;
        end
      end

      HALT: begin
        if (ctrl) begin
          pc_next = ctrl_pc;
        end
        if (!halt_req) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC and instruction holding registers. The instruction word and its
  // PC are loaded only on an accepted response and then stay put through HOLD
  // so decode sees a stable value for as long as it stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      kill         <= kill_next;
      misalign_err <= misalign_next;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  // Handshake outputs come straight from the state register, so no input has
  // a combinational path to any output.
  always_comb begin
    imem_req    = (state == REQ);
    imem_addr   = pc;
    instr_valid = (state == HOLD);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Scoreboard bench for fetch_sequencer. Directed tests push the request
// addresses, delivered instructions and misalignment pulses they expect into
// queues; an independent monitor pops and compares whenever the DUT raises
// imem_req, completes an instr_valid/instr_ready transfer, or pulses
// misalign_err. A behavioural memory answers each request after a
// programmable number of cycles with the word 0xC0DE_<addr[15:0]>.
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_instr_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        halt_req;
  logic        misalign_err;

  int          checks   = 0;
  int          failures = 0;

  logic [31:0] exp_req[$];
  exp_instr_t  exp_instr[$];
  int          exp_misalign = 0;

  int          mem_lat = 1;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .halt_req       (halt_req),
    .misalign_err   (misalign_err)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives a one-cycle control-flow pulse starting now, then releases it just
  // after the edge that samples it.
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic tv);
    redirect_valid = rv;
    redirect_pc    = rpc;
    trap_valid     = tv;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    trap_valid     = 1'b0;
  endtask

  // Advances to the negedge of the next cycle with imem_req high.
  task automatic waitReq(input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 40);
    if (!imem_req) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout_%s imem_req=%b expected=1", what, imem_req);
    end
  endtask

  // Advances to the negedge of the next cycle with instr_valid high.
  task automatic waitValid(input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 40);
    if (!instr_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout_%s instr_valid=%b expected=1", what, instr_valid);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural instruction memory: a request seen in cycle c is answered with
  // a one-cycle rvalid in cycle c+mem_lat. It keeps no knowledge of reset, so
  // a request cut short by reset produces a stale response.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] pend_addr;
    pend        = 1'b0;
    cnt         = 0;
    pend_addr   = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      @(negedge clk);
      if (imem_req) begin
        pend      = 1'b1;
        cnt       = mem_lat;
        pend_addr = imem_addr;
      end
    end
  end

  // Monitor: every request, transfer and misalignment pulse must match the
  // oldest outstanding expectation; anything unexpected is a failure.
  initial begin
    exp_instr_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (exp_req.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_imem_req addr=%h expected no request", imem_addr);
        end else begin
          a = exp_req.pop_front();
          checkOutput("imem_addr", imem_addr, a);
        end
      end
      if (instr_valid && instr_ready) begin
        if (exp_instr.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_transfer pc=%h instr=%h expected no transfer",
                   instr_pc, instr);
        end else begin
          e = exp_instr.pop_front();
          checkOutput("instr_pc", instr_pc, e.pc);
          checkOutput("instr", instr, e.word);
        end
      end
      if (misalign_err) begin
        checks++;
        if (exp_misalign == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_misalign_err actual=1 expected=0 at %0t", $time);
        end else begin
          exp_misalign--;
        end
      end
    end
  end

  // Safety net so the run always ends even if the DUT wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout reached");
    $fatal(1, "[TB] global timeout");
  end

  // Directed test sequence.
  initial begin
    rst_n          = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    trap_valid     = 1'b0;
    halt_req       = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_imem_req", {31'h0, imem_req}, 32'h0);
    checkOutput("reset_imem_addr", imem_addr, 32'h0000_0000);
    checkOutput("reset_instr_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("reset_misalign", {31'h0, misalign_err}, 32'h0);

    // Sequential fetch 0x0, 0x4, 0x8; halt raised during the third WAIT lets
    // that in-flight fetch finish and then stops fetching.
    $display("[TB] test: sequential fetch and halt during WAIT");
    exp_req.push_back(32'h0000_0000);
    exp_req.push_back(32'h0000_0004);
    exp_req.push_back(32'h0000_0008);
    exp_instr.push_back('{32'h0000_0000, 32'hC0DE_0000});
    exp_instr.push_back('{32'h0000_0004, 32'hC0DE_0004});
    exp_instr.push_back('{32'h0000_0008, 32'hC0DE_0008});
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    waitReq("fetch0");
    waitReq("fetch4");
    waitReq("fetch8");
    nextCycle();
    halt_req = 1'b1;
    repeat (6) nextCycle();
    checkOutput("halted_no_valid", {31'h0, instr_valid}, 32'h0);

    // Decode stalls five cycles with instr_ready low.
    $display("[TB] test: decode stall in HOLD");
    exp_req.push_back(32'h0000_000C);
    exp_instr.push_back('{32'h0000_000C, 32'hC0DE_000C});
    instr_ready = 1'b0;
    halt_req    = 1'b0;
    waitValid("stall");
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall_valid", {31'h0, instr_valid}, 32'h1);
      checkOutput("stall_instr", instr, 32'hC0DE_000C);
      checkOutput("stall_pc", instr_pc, 32'h0000_000C);
    end
    nextCycle();
    instr_ready = 1'b1;
    repeat (5) nextCycle();

    // Redirect to 0x200 in the WAIT cycle that also carries rvalid.
    $display("[TB] test: redirect with same-cycle response");
    exp_req.push_back(32'h0000_0010);
    exp_req.push_back(32'h0000_0200);
    exp_instr.push_back('{32'h0000_0200, 32'hC0DE_0200});
    halt_req = 1'b0;
    waitReq("pre_redirect");
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0200, 1'b0);
    waitReq("redirect_target");
    checkOutput("discard_no_valid", {31'h0, instr_valid}, 32'h0);
    nextCycle();
    halt_req = 1'b1;
    repeat (5) nextCycle();

    // Misaligned redirect goes to the trap vector and pulses misalign_err.
    $display("[TB] test: misaligned redirect");
    exp_req.push_back(32'h0000_0204);
    exp_req.push_back(32'h0000_0100);
    exp_instr.push_back('{32'h0000_0100, 32'hC0DE_0100});
    exp_misalign = exp_misalign + 1;
    halt_req = 1'b0;
    waitReq("pre_misalign");
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0202, 1'b0);
    waitReq("misalign_target");
    nextCycle();
    halt_req = 1'b1;
    repeat (5) nextCycle();

    // Trap and misaligned redirect together: trap wins, no misalign pulse.
    $display("[TB] test: trap beats misaligned redirect");
    exp_req.push_back(32'h0000_0104);
    exp_req.push_back(32'h0000_0100);
    exp_instr.push_back('{32'h0000_0100, 32'hC0DE_0100});
    halt_req = 1'b0;
    waitReq("pre_trap");
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0302, 1'b1);
    waitReq("trap_target");
    nextCycle();
    halt_req = 1'b1;
    repeat (5) nextCycle();

    // Redirect during REQ: the later response is killed.
    $display("[TB] test: redirect during REQ");
    exp_req.push_back(32'h0000_0104);
    exp_req.push_back(32'h0000_0080);
    exp_instr.push_back('{32'h0000_0080, 32'hC0DE_0080});
    halt_req = 1'b0;
    waitReq("pre_kill");
    applyStimulus(1'b1, 32'h0000_0080, 1'b0);
    waitReq("kill_target");
    nextCycle();
    halt_req = 1'b1;
    repeat (5) nextCycle();

    // Redirect to 0x40 while halted, then resume.
    $display("[TB] test: redirect while halted");
    applyStimulus(1'b1, 32'h0000_0040, 1'b0);
    repeat (3) nextCycle();
    exp_req.push_back(32'h0000_0040);
    exp_instr.push_back('{32'h0000_0040, 32'hC0DE_0040});
    halt_req = 1'b0;
    waitReq("halt_resume");
    nextCycle();
    halt_req = 1'b1;
    repeat (5) nextCycle();

    // Asynchronous reset mid-WAIT with a slow memory; its stale response lands
    // after reset release and must be ignored.
    $display("[TB] test: reset during WAIT");
    mem_lat = 3;
    exp_req.push_back(32'h0000_0044);
    halt_req = 1'b0;
    waitReq("pre_reset");
    nextCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_imem_req", {31'h0, imem_req}, 32'h0);
    checkOutput("async_reset_imem_addr", imem_addr, 32'h0000_0000);
    checkOutput("async_reset_instr_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("async_reset_instr", instr, 32'h0);
    checkOutput("async_reset_instr_pc", instr_pc, 32'h0);
    checkOutput("async_reset_misalign", {31'h0, misalign_err}, 32'h0);
    mem_lat = 1;
    exp_req.push_back(32'h0000_0000);
    exp_instr.push_back('{32'h0000_0000, 32'hC0DE_0000});
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitReq("restart");
    nextCycle();
    halt_req = 1'b1;
    repeat (8) nextCycle();

    checkOutput("req_queue_drained", exp_req.size(), 32'h0);
    checkOutput("instr_queue_drained", exp_instr.size(), 32'h0);
    checkOutput("misalign_drained", exp_misalign, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns and sequences the program counter for the RISC-V core. It issues single-outstanding requests to instruction memory and presents fetched instructions to decode through a valid/ready handshake. It applies redirects from execute and trap entries, and supports a halt/resume request. It replaces ad-hoc PC write-enable logic with one FSM that decides when and to what value the PC advances.

## Interface

- N, 32, address/data width (bits)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request, one cycle per fetch
- imem_addr  out  N  fetch address (current PC)
- imem_rvalid  in  1  read data valid, ≥1 cycle after imem_req
- imem_rdata  in  N  instruction word
- instr_valid  out  1  instruction available to decode
- instr  out  N  instruction word
- instr_pc  out  N  PC of instr
- instr_ready  in  1  decode accepts instr
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  N  redirect target
- trap_valid  in  1  trap entry, one-cycle pulse
- halt_req  in  1  level; hold fetch while high
- misalign_err  out  1  one-cycle pulse: redirect target with [1:0] != 0

## Operation

- States: IDLE, REQ, WAIT, HOLD, HALT. Internal regs: pc, kill flag.
- IDLE: entered on reset; next edge -> REQ (or HALT if halt_req).
- REQ: imem_req=1, imem_addr=pc; next -> WAIT.
- WAIT: on imem_rvalid with kill=0: capture instr=imem_rdata, instr_pc=pc, instr_valid=1 -> HOLD. With kill=1: discard, clear kill -> REQ.
- HOLD: instr_valid=1, instr/instr_pc stable until instr_valid&&instr_ready. On transfer: pc <= pc+4 -> REQ (HALT if halt_req).
- HALT: no requests; -> REQ when halt_req low.
- Control-flow priority: trap_valid > redirect_valid > sequential.
  - Trap: pc <= TRAP_VEC.
  - Redirect, aligned: pc <= redirect_pc.
  - Redirect, misaligned: pc <= TRAP_VEC, misalign_err=1 next cycle.
- Effect of trap/redirect by state:
  - REQ or WAIT (request outstanding): set kill (in WAIT only if rvalid not same cycle; rvalid same cycle is discarded) and update pc; the response is discarded.
  - HOLD: instr_valid drops next cycle, pc updated -> REQ; the held instruction is squashed even if instr_ready was high that cycle.
  - IDLE/HALT: pc updated, state unchanged.
- pc+4 wraps modulo 2^N. pc[1:0] is always 0.
- Only one request outstanding; imem_req never asserted while in WAIT.

## Timing

- Reset (rst_n low, asynchronous): state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign_err=0. Applies immediately, independent of clk.
- imem_req and instr_valid are decoded from registered state only; no combinational path from any input to any output.
- Startup: first edge after rst_n rises: IDLE->REQ; imem_req high during cycle 1.
- Fetch latency: rvalid in cycle k -> instr_valid high in cycle k+1.
- Back-to-back: transfer in cycle t -> next imem_req in cycle t+1. Minimum 3 cycles per instruction with 1-cycle memory.
- Redirect/trap sampled on the edge at the end of the pulse cycle. New pc appears on imem_addr in the next REQ.
- imem_rvalid outside WAIT is ignored, including a late response after reset.
- halt_req sampled only at REQ entry points (IDLE exit, HOLD transfer, kill recovery). A fetch in flight completes normally.

## Test plan

- Reset release, 1-cycle memory, instr_ready=1: imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; instr equals memory contents.
- instr_ready low 5 cycles in HOLD: instr/instr_pc stable and instr_valid high throughout; exactly one transfer; no extra imem_req.
- redirect_valid to 0x200 in the WAIT cycle with rvalid same cycle: response discarded, instr_valid stays 0, next imem_addr=0x200.
- redirect_pc=0x202: misalign_err pulses once; next imem_addr=TRAP_VEC (0x100). Same cycle as trap_valid: trap wins and misalign_err stays 0.
- halt_req high during WAIT: in-flight fetch delivered, then no imem_req. Redirect to 0x40 while halted: after halt_req falls, imem_addr=0x40.
- rst_n pulsed low mid-WAIT, then a stale rvalid: all outputs at reset values asynchronously; stale response ignored; fetch restarts at RESET_PC.
